// File: rtl/branch_predict_checker_if.sv
// Bundles the predictor-side push port, the execute-side resolve port and
// the update/redirect outputs of the branch prediction checker.
interface branch_predict_checker_if #(
    parameter int P_DEPTH_N = 3
);
    // Push side (from the predictor stage)
    logic                 iPUSH_VALID;
    logic                 iPUSH_PREDICT;
    logic [31:0]          iPUSH_ADDR;
    logic [31:0]          iPUSH_INST_ADDR;
    logic                 oPUSH_FULL;
    logic [P_DEPTH_N:0]   oCOUNT;
    // Resolve side (from execute)
    logic                 iEXE_VALID;
    logic                 iEXE_IS_BRANCH;
    logic                 iEXE_TAKEN;
    logic [31:0]          iEXE_ADDR;
    // Predictor update and fetch redirect
    logic                 oJUMP_STB;
    logic                 oJUMP_HIT;
    logic [31:0]          oJUMP_ADDR;
    logic [31:0]          oJUMP_INST_ADDR;
    logic                 oMISS_VALID;
    logic [31:0]          oMISS_ADDR;

    // Environment side: drives pushes and resolutions, observes results
    modport master (
        output iPUSH_VALID, iPUSH_PREDICT, iPUSH_ADDR, iPUSH_INST_ADDR,
        output iEXE_VALID, iEXE_IS_BRANCH, iEXE_TAKEN, iEXE_ADDR,
        input  oPUSH_FULL, oCOUNT,
        input  oJUMP_STB, oJUMP_HIT, oJUMP_ADDR, oJUMP_INST_ADDR,
        input  oMISS_VALID, oMISS_ADDR
    );

    // Checker side
    modport slave (
        input  iPUSH_VALID, iPUSH_PREDICT, iPUSH_ADDR, iPUSH_INST_ADDR,
        input  iEXE_VALID, iEXE_IS_BRANCH, iEXE_TAKEN, iEXE_ADDR,
        output oPUSH_FULL, oCOUNT,
        output oJUMP_STB, oJUMP_HIT, oJUMP_ADDR, oJUMP_INST_ADDR,
        output oMISS_VALID, oMISS_ADDR
    );
endinterface

// File: rtl/branch_predict_checker.sv
// In-order queue of outstanding branch predictions. Each entry is resolved
// by execute in issue order; the checker compares prediction and outcome,
// emits a predictor update strobe and a registered mispredict redirect, and
// drops every younger prediction when a mispredict is found.
module branch_predict_checker #(
    parameter int P_DEPTH   = 8,
    parameter int P_DEPTH_N = 3
)(
    input  logic iCLOCK,
    input  logic iRESET_SYNC,
    input  logic iFLUSH,
    branch_predict_checker_if.slave bus
);
    localparam logic [P_DEPTH_N:0] DEPTH_C = (P_DEPTH_N+1)'(P_DEPTH);

    // Sequential fall-through address after an instruction (wraps mod 2^32)
    function automatic logic [31:0] seq_addr(input logic [31:0] inst_addr);
        return inst_addr + 32'd4;
    endfunction

    // Entry storage (data only, never reset)
    logic                   pred_mem [P_DEPTH];
    logic [31:0]            addr_mem [P_DEPTH];
    logic [31:0]            inst_mem [P_DEPTH];

    // Queue control
    logic [P_DEPTH_N-1:0]   wr_ptr_p0;
    logic [P_DEPTH_N-1:0]   rd_ptr_p0;
    logic [P_DEPTH_N:0]     count_p0;

    // Registered results
    logic                   jump_stb_p1;
    logic                   jump_hit_p1;
    logic [31:0]            jump_addr_p1;
    logic [31:0]            jump_inst_p1;
    logic                   miss_valid_p1;
    logic [31:0]            miss_addr_p1;

    logic                   full;
    logic                   pop_acc;
    logic                   push_acc;
    logic                   head_pred;
    logic [31:0]            head_addr;
    logic [31:0]            head_inst;
    logic                   actual_taken;
    logic                   miss;

    assign full         = (count_p0 == DEPTH_C);
    assign pop_acc      = bus.iEXE_VALID && (count_p0 != '0);
    assign push_acc     = bus.iPUSH_VALID && (!full || pop_acc);
    assign head_pred    = pred_mem[rd_ptr_p0];
    assign head_addr    = addr_mem[rd_ptr_p0];
    assign head_inst    = inst_mem[rd_ptr_p0];
    assign actual_taken = bus.iEXE_IS_BRANCH && bus.iEXE_TAKEN;
    // A predicted-taken branch with the right direction still misses on a wrong target
    assign miss = pop_acc &&
                  ((head_pred != actual_taken) ||
                   (head_pred && actual_taken && (head_addr != bus.iEXE_ADDR)));

    // Store an accepted push unless a flush or mispredict discards it this edge
    always_ff @(posedge iCLOCK) begin
        if (push_acc && !iFLUSH && !miss && !iRESET_SYNC) begin
            pred_mem[wr_ptr_p0] <= bus.iPUSH_PREDICT;
            addr_mem[wr_ptr_p0] <= bus.iPUSH_ADDR;
            inst_mem[wr_ptr_p0] <= bus.iPUSH_INST_ADDR;
        end
    end

    // Pointer and occupancy update; flush and mispredict both empty the queue
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC || iFLUSH || miss) begin
            wr_ptr_p0 <= '0;
            rd_ptr_p0 <= '0;
            count_p0  <= '0;
        end else begin
            if (push_acc) wr_ptr_p0 <= wr_ptr_p0 + 1'b1;
            if (pop_acc)  rd_ptr_p0 <= rd_ptr_p0 + 1'b1;
            case ({push_acc, pop_acc})
                2'b10:   count_p0 <= count_p0 + 1'b1;
                2'b01:   count_p0 <= count_p0 - 1'b1;
                default: count_p0 <= count_p0;
            endcase
        end
    end

    // Pop -> registered update/redirect; fields hold between pops
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            jump_stb_p1   <= 1'b0;
            jump_hit_p1   <= 1'b0;
            jump_addr_p1  <= 32'h0;
            jump_inst_p1  <= 32'h0;
            miss_valid_p1 <= 1'b0;
            miss_addr_p1  <= 32'h0;
        end else begin
            jump_stb_p1   <= pop_acc && !iFLUSH && bus.iEXE_IS_BRANCH;
            miss_valid_p1 <= miss && !iFLUSH;
            if (pop_acc && !iFLUSH) begin
                jump_hit_p1  <= bus.iEXE_TAKEN;
                jump_addr_p1 <= bus.iEXE_ADDR;
                jump_inst_p1 <= head_inst;
                miss_addr_p1 <= actual_taken ? bus.iEXE_ADDR : seq_addr(head_inst);
            end
        end
    end

    assign bus.oPUSH_FULL      = full;
    assign bus.oCOUNT          = count_p0;
    assign bus.oJUMP_STB       = jump_stb_p1;
    assign bus.oJUMP_HIT       = jump_hit_p1;
    assign bus.oJUMP_ADDR      = jump_addr_p1;
    assign bus.oJUMP_INST_ADDR = jump_inst_p1;
    assign bus.oMISS_VALID     = miss_valid_p1;
    assign bus.oMISS_ADDR      = miss_addr_p1;
endmodule

// File: tb/tb_branch_predict_checker.sv
// Bench for branch_predict_checker: a queue-based reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_branch_predict_checker;
    localparam int DEPTH   = 8;
    localparam int DEPTH_N = 3;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    branch_predict_checker_if #(.P_DEPTH_N(DEPTH_N)) bus ();

    branch_predict_checker #(
        .P_DEPTH   (DEPTH),
        .P_DEPTH_N (DEPTH_N)
    ) dut (
        .iCLOCK      (clk),
        .iRESET_SYNC (rst),
        .iFLUSH      (flush),
        .bus         (bus.slave)
    );

    typedef struct packed {
        logic        pred;
        logic [31:0] addr;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    logic        exp_stb, exp_hit, exp_mv;
    logic [31:0] exp_ja, exp_ji, exp_ma;
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          cmp_en  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    // Reference model: an in-order list of predictions, resolved at each rising edge
    always @(posedge clk) begin
        ent_t e;
        bit   m_full, m_pop, m_act, m_miss;
        if (rst) begin
            mq.delete();
            exp_stb = 0; exp_hit = 0; exp_mv = 0;
            exp_ja = 0;  exp_ji = 0;  exp_ma = 0;
        end else begin
            m_full  = (mq.size() == DEPTH);
            m_pop   = bus.iEXE_VALID && (mq.size() != 0);
            exp_stb = 0;
            exp_mv  = 0;
            if (flush) begin
                mq.delete();
            end else begin
                m_miss = 0;
                if (m_pop) begin
                    e      = mq[0];
                    m_act  = bus.iEXE_IS_BRANCH && bus.iEXE_TAKEN;
                    m_miss = (e.pred != m_act) || (e.pred && m_act && e.addr != bus.iEXE_ADDR);
                    exp_stb = bus.iEXE_IS_BRANCH;
                    exp_hit = bus.iEXE_TAKEN;
                    exp_ja  = bus.iEXE_ADDR;
                    exp_ji  = e.inst;
                    exp_mv  = m_miss;
                    exp_ma  = m_act ? bus.iEXE_ADDR : e.inst + 32'd4;
                end
                if (m_miss) begin
                    mq.delete();
                end else begin
                    if (m_pop) void'(mq.pop_front());
                    if (bus.iPUSH_VALID && (!m_full || m_pop))
                        mq.push_back({bus.iPUSH_PREDICT, bus.iPUSH_ADDR, bus.iPUSH_INST_ADDR});
                end
            end
        end
    end

    // Compare DUT against the model on the falling edge of every cycle
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_count", 32'(bus.oCOUNT), 32'(mq.size()));
            chk("m_full", 32'(bus.oPUSH_FULL), 32'(mq.size() == DEPTH));
            chk("m_jump_stb", 32'(bus.oJUMP_STB), 32'(exp_stb));
            chk("m_miss_valid", 32'(bus.oMISS_VALID), 32'(exp_mv));
            if (exp_stb) begin
                chk("m_jump_hit", 32'(bus.oJUMP_HIT), 32'(exp_hit));
                chk("m_jump_addr", bus.oJUMP_ADDR, exp_ja);
                chk("m_jump_inst", bus.oJUMP_INST_ADDR, exp_ji);
            end
            if (exp_mv) chk("m_miss_addr", bus.oMISS_ADDR, exp_ma);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.iPUSH_VALID     = 0;
        bus.iPUSH_PREDICT   = 0;
        bus.iPUSH_ADDR      = 0;
        bus.iPUSH_INST_ADDR = 0;
        bus.iEXE_VALID      = 0;
        bus.iEXE_IS_BRANCH  = 0;
        bus.iEXE_TAKEN      = 0;
        bus.iEXE_ADDR       = 0;
        flush               = 0;
    endtask

    task automatic set_push(input logic p, input logic [31:0] a, input logic [31:0] i);
        bus.iPUSH_VALID     = 1;
        bus.iPUSH_PREDICT   = p;
        bus.iPUSH_ADDR      = a;
        bus.iPUSH_INST_ADDR = i;
    endtask

    task automatic set_exe(input logic br, input logic tk, input logic [31:0] a);
        bus.iEXE_VALID     = 1;
        bus.iEXE_IS_BRANCH = br;
        bus.iEXE_TAKEN     = tk;
        bus.iEXE_ADDR      = a;
    endtask

    task automatic push_only(input logic p, input logic [31:0] a, input logic [31:0] i);
        set_push(p, a, i); cyc(); idle();
    endtask

    task automatic exe_only(input logic br, input logic tk, input logic [31:0] a);
        set_exe(br, tk, a); cyc(); idle();
    endtask

    task automatic do_flush();
        flush = 1; cyc(); idle();
    endtask

    initial begin
        idle();
        rst = 1;
        cyc(); cyc();
        chk("rst_count", 32'(bus.oCOUNT), 0);
        chk("rst_full", 32'(bus.oPUSH_FULL), 0);
        chk("rst_stb", 32'(bus.oJUMP_STB), 0);
        chk("rst_hit", 32'(bus.oJUMP_HIT), 0);
        chk("rst_miss", 32'(bus.oMISS_VALID), 0);
        chk("rst_jaddr", bus.oJUMP_ADDR, 0);
        chk("rst_jinst", bus.oJUMP_INST_ADDR, 0);
        chk("rst_maddr", bus.oMISS_ADDR, 0);
        rst    = 0;
        cmp_en = 1;

        // Fill, overflow, then push+pop while full
        for (int i = 0; i < 8; i++) push_only(1, 32'h1000 + 32'(i * 16), 32'(i * 4));
        chk("fill_count", 32'(bus.oCOUNT), 8);
        chk("fill_full", 32'(bus.oPUSH_FULL), 1);
        push_only(0, 0, 32'h999);
        chk("ovf_count", 32'(bus.oCOUNT), 8);
        set_push(1, 32'h1080, 32'h20); set_exe(1, 1, 32'h1000); cyc(); idle();
        chk("fullpp_count", 32'(bus.oCOUNT), 8);
        chk("fullpp_stb", 32'(bus.oJUMP_STB), 1);
        chk("fullpp_miss", 32'(bus.oMISS_VALID), 0);
        chk("fullpp_inst", bus.oJUMP_INST_ADDR, 32'h0);
        exe_only(1, 1, 32'h1010);
        chk("pop2_count", 32'(bus.oCOUNT), 7);
        chk("pop2_inst", bus.oJUMP_INST_ADDR, 32'h4);
        do_flush();

        // Correct prediction
        push_only(1, 32'h100, 32'h40);
        exe_only(1, 1, 32'h100);
        chk("ok_stb", 32'(bus.oJUMP_STB), 1);
        chk("ok_hit", 32'(bus.oJUMP_HIT), 1);
        chk("ok_inst", bus.oJUMP_INST_ADDR, 32'h40);
        chk("ok_jaddr", bus.oJUMP_ADDR, 32'h100);
        chk("ok_miss", 32'(bus.oMISS_VALID), 0);

        // Direction miss clears younger entries
        push_only(0, 0, 32'h80);
        push_only(1, 32'h500, 32'h84);
        exe_only(1, 1, 32'h200);
        chk("dmiss_valid", 32'(bus.oMISS_VALID), 1);
        chk("dmiss_addr", bus.oMISS_ADDR, 32'h200);
        chk("dmiss_count", 32'(bus.oCOUNT), 0);

        // Predicted taken, actually not taken, fall-through wraps to zero
        push_only(1, 32'h300, 32'hFFFF_FFFC);
        exe_only(1, 0, 32'h0);
        chk("ntmiss_valid", 32'(bus.oMISS_VALID), 1);
        chk("ntmiss_addr", bus.oMISS_ADDR, 32'h0);
        chk("ntmiss_hit", 32'(bus.oJUMP_HIT), 0);

        // Non-branch predicted taken is a miss without an update strobe
        push_only(1, 32'h10, 32'h20);
        exe_only(0, 0, 32'h0);
        chk("nb_stb", 32'(bus.oJUMP_STB), 0);
        chk("nb_miss", 32'(bus.oMISS_VALID), 1);
        chk("nb_addr", bus.oMISS_ADDR, 32'h24);

        // Push in the same cycle as a miss is dropped
        push_only(0, 0, 32'h90);
        set_push(1, 32'h60, 32'h94); set_exe(1, 1, 32'h44); cyc(); idle();
        chk("mdrop_count", 32'(bus.oCOUNT), 0);

        // Flush with simultaneous push and pop
        push_only(1, 32'h10, 32'h20);
        flush = 1; set_exe(1, 1, 32'h10); set_push(1, 32'h30, 32'h40); cyc(); idle();
        chk("fl_stb", 32'(bus.oJUMP_STB), 0);
        chk("fl_miss", 32'(bus.oMISS_VALID), 0);
        chk("fl_count", 32'(bus.oCOUNT), 0);

        // Resolve while empty
        exe_only(1, 1, 32'h10);
        chk("empty_stb", 32'(bus.oJUMP_STB), 0);
        chk("empty_miss", 32'(bus.oMISS_VALID), 0);

        // Pointer wrap with full queue and 20 push/pop pairs
        for (int i = 0; i < 8; i++) push_only(1, 32'h2000 + 32'(i * 8), 32'h500 + 32'(i * 4));
        for (int j = 0; j < 20; j++) begin
            set_push(1, 32'h2000 + 32'((j + 8) * 8), 32'h500 + 32'((j + 8) * 4));
            set_exe(1, 1, 32'h2000 + 32'(j * 8));
            cyc(); idle();
            chk("wrap_inst", bus.oJUMP_INST_ADDR, 32'h500 + 32'(j * 4));
            chk("wrap_miss", 32'(bus.oMISS_VALID), 0);
            chk("wrap_count", 32'(bus.oCOUNT), 8);
        end
        do_flush();

        // Random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            idle();
            rst   = (k == 1500);
            flush = ($urandom_range(39) == 0);
            if ($urandom_range(2) != 0)
                set_push(1'($urandom_range(1)), 32'h100 + 32'($urandom_range(3) * 4),
                         32'($urandom_range(255) * 4));
            if ($urandom_range(2) == 0)
                set_exe(1'($urandom_range(3) != 0), 1'($urandom_range(1)),
                        (mq.size() > 0 && $urandom_range(3) != 0) ? mq[0].addr
                                                                  : 32'h100 + 32'($urandom_range(3) * 4));
            cyc();
        end
        idle();
        rst = 0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
